// File: rtl/tm_pkg.sv
// Shared Tsetlin-machine types and helpers used by the vote, clause and trainer blocks.
package tm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } tm_state_e;

    function automatic int vote_w(input int clauses);
        return $clog2(clauses + 1) + 1;
    endfunction

    function automatic int cls_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int clamp_vote(input int v, input int t);
        if (v > t) return t;
        if (v < -t) return -t;
        return v;
    endfunction

endpackage

// File: rtl/tm_vote_calc.sv
// Combinational clamped class vote: popcount(pos) - popcount(neg), limited to +/-THRESHOLD.
module tm_vote_calc
    import tm_pkg::*;
#(
    parameter int CLAUSES   = 2,
    parameter int THRESHOLD = CLAUSES,
    parameter int VOTE_W    = vote_w(CLAUSES)
) (
    input  logic [CLAUSES-1:0]       pos_i,
    input  logic [CLAUSES-1:0]       neg_i,
    output logic signed [VOTE_W-1:0] vote_o
);

    localparam int PC_W = VOTE_W - 1;

    logic [PC_W-1:0]          pc_p;
    logic [PC_W-1:0]          pc_n;
    logic signed [VOTE_W-1:0] diff;

    always_comb begin
        pc_p = '0;
        pc_n = '0;
        for (int i = 0; i < CLAUSES; i++) begin
            pc_p = pc_p + PC_W'(pos_i[i]);
            pc_n = pc_n + PC_W'(neg_i[i]);
        end
        diff   = $signed({1'b0, pc_p}) - $signed({1'b0, pc_n});
        vote_o = VOTE_W'(clamp_vote(int'(diff), THRESHOLD));
    end

endmodule

// File: rtl/tm_class_vote_argmax.sv
// Sequential per-class vote and argmax, one class evaluated per cycle.
module tm_class_vote_argmax
    import tm_pkg::*;
#(
    parameter int NUM_CLASSES = 3,
    parameter int CLAUSES     = 2,
    parameter int THRESHOLD   = CLAUSES,
    localparam int CLS_W      = cls_w(NUM_CLASSES),
    localparam int VOTE_W     = vote_w(CLAUSES),
    localparam int VEC_W      = NUM_CLASSES * CLAUSES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [VEC_W-1:0]         pos_clauses,
    input  logic [VEC_W-1:0]         neg_clauses,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLS_W-1:0]         class_out,
    output logic signed [VOTE_W-1:0] best_vote
);

    tm_state_e                state_q, state_d;
    logic [CLS_W-1:0]         idx_q, idx_d;
    logic [VEC_W-1:0]         pos_q, pos_d;
    logic [VEC_W-1:0]         neg_q, neg_d;
    logic [CLS_W-1:0]         class_q, class_d;
    logic signed [VOTE_W-1:0] best_q, best_d;

    logic [CLAUSES-1:0]       sel_pos;
    logic [CLAUSES-1:0]       sel_neg;
    logic signed [VOTE_W-1:0] vote;

    assign sel_pos = pos_q[int'(idx_q) * CLAUSES +: CLAUSES];
    assign sel_neg = neg_q[int'(idx_q) * CLAUSES +: CLAUSES];

    tm_vote_calc #(
        .CLAUSES   (CLAUSES),
        .THRESHOLD (THRESHOLD),
        .VOTE_W    (VOTE_W)
    ) u_vote (
        .pos_i  (sel_pos),
        .neg_i  (sel_neg),
        .vote_o (vote)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        class_d = class_q;
        best_d  = best_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pos_d   = pos_clauses;
                    neg_d   = neg_clauses;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (idx_q == '0 || vote > best_q) begin
                    best_d  = vote;
                    class_d = idx_q;
                end
                if (idx_q == CLS_W'(NUM_CLASSES - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pos_q   <= '0;
            neg_q   <= '0;
            class_q <= '0;
            best_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            class_q <= class_d;
            best_q  <= best_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign class_out = class_q;
    assign best_vote = best_q;

endmodule

// File: tb/tb_tm_class_vote_argmax.sv
// Scoreboard bench: default 3x2 instance plus a 4x4 T=2 clamp instance.
module tb_tm_class_vote_argmax;

    typedef struct {
        int cls;
        int vote;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              iv_a = 1'b0, ir_a, ov_a, or_a = 1'b1;
    logic [5:0]        pos_a = '0, neg_a = '0;
    logic [1:0]        cls_a;
    logic signed [2:0] vote_a;

    logic              iv_b = 1'b0, ir_b, ov_b, or_b = 1'b1;
    logic [15:0]       pos_b = '0, neg_b = '0;
    logic [1:0]        cls_b;
    logic signed [3:0] vote_b;

    int   total = 0;
    int   bad   = 0;
    exp_t qa[$];
    exp_t qb[$];
    bit   rnd_or = 1'b0;

    tm_class_vote_argmax #(.NUM_CLASSES(3), .CLAUSES(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a),
        .pos_clauses(pos_a), .neg_clauses(neg_a), .out_valid(ov_a),
        .out_ready(or_a), .class_out(cls_a), .best_vote(vote_a)
    );

    tm_class_vote_argmax #(.NUM_CLASSES(4), .CLAUSES(4), .THRESHOLD(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b),
        .pos_clauses(pos_b), .neg_clauses(neg_b), .out_valid(ov_b),
        .out_ready(or_b), .class_out(cls_b), .best_vote(vote_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int n, input int c, input int t,
                                   input logic [63:0] p, input logic [63:0] ng);
        exp_t r;
        r.cls  = 0;
        r.vote = 0;
        for (int k = 0; k < n; k++) begin
            int v;
            v = 0;
            for (int j = 0; j < c; j++) begin
                v += int'(p[k*c+j]);
                v -= int'(ng[k*c+j]);
            end
            if (v > t) v = t;
            if (v < -t) v = -t;
            if (k == 0 || v > r.vote) begin
                r.vote = v;
                r.cls  = k;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && ov_a && or_a) begin
            if (qa.size() == 0) check("a_unexpected", 1, 0);
            else begin
                exp_t e;
                e = qa.pop_front();
                check("a_cls", int'(cls_a), e.cls);
                check("a_vote", int'(vote_a), e.vote);
            end
        end
        if (!rst && ov_b && or_b) begin
            if (qb.size() == 0) check("b_unexpected", 1, 0);
            else begin
                exp_t e;
                e = qb.pop_front();
                check("b_cls", int'(cls_b), e.cls);
                check("b_vote", int'(vote_b), e.vote);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_or) or_b = 1'($urandom_range(0, 1));
    end

    task automatic send_a(input logic [5:0] p, input logic [5:0] n);
        int cnt;
        iv_a  = 1'b1;
        pos_a = p;
        neg_a = n;
        cnt   = 0;
        @(negedge clk);
        while (!ir_a && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (!ir_a) check("a_accept_timeout", 0, 1);
        else qa.push_back(model(3, 2, 2, 64'(p), 64'(n)));
        @(posedge clk);
        #1 iv_a = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] p, input logic [15:0] n);
        int cnt;
        iv_b  = 1'b1;
        pos_b = p;
        neg_b = n;
        cnt   = 0;
        @(negedge clk);
        while (!ir_b && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (!ir_b) check("b_accept_timeout", 0, 1);
        else qb.push_back(model(4, 4, 2, 64'(p), 64'(n)));
        @(posedge clk);
        #1 iv_b = 1'b0;
    endtask

    task automatic wait_out_a(output int lat);
        lat = 0;
        while (!ov_a && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!ov_a) check("a_out_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int      lat;
        int      cnt;
        int      hold_cls;
        int      hold_vote;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", int'(ir_a), 1);
        check("rst_out_valid", int'(ov_a), 0);
        check("rst_cls", int'(cls_a), 0);
        check("rst_vote", int'(vote_a), 0);
        check("rst_b_in_ready", int'(ir_b), 1);

        send_a(6'b000111, 6'b000000);
        wait_out_a(lat);
        check("t1_latency", lat, 3);
        check("t1_cls", int'(cls_a), 0);
        check("t1_vote", int'(vote_a), 2);
        @(posedge clk);
        #1;

        send_a(6'b000000, 6'b000000);
        wait_out_a(lat);
        check("t2_zero_cls", int'(cls_a), 0);
        check("t2_zero_vote", int'(vote_a), 0);
        @(posedge clk);
        #1;

        send_a(6'b010100, 6'b000000);
        wait_out_a(lat);
        check("t2_tie_cls", int'(cls_a), 1);
        @(posedge clk);
        #1;

        send_a(6'b000000, 6'b011111);
        wait_out_a(lat);
        check("t3_neg_cls", int'(cls_a), 2);
        check("t3_neg_vote", int'(vote_a), -1);
        @(posedge clk);
        #1;

        or_a = 1'b0;
        send_a(6'b110100, 6'b000001);
        wait_out_a(lat);
        hold_cls  = int'(cls_a);
        hold_vote = int'(vote_a);
        for (int i = 0; i < 5; i++) begin
            iv_a  = 1'b1;
            pos_a = 6'($urandom);
            neg_a = 6'($urandom);
            @(posedge clk);
            #1;
            check("t4_hold_valid", int'(ov_a), 1);
            check("t4_hold_ready", int'(ir_a), 0);
            check("t4_hold_cls", int'(cls_a), hold_cls);
            check("t4_hold_vote", int'(vote_a), hold_vote);
        end
        iv_a = 1'b0;
        or_a = 1'b1;
        @(posedge clk);
        #1;
        check("t4_after_valid", int'(ov_a), 0);
        check("t4_after_ready", int'(ir_a), 1);
        @(posedge clk);
        #1;
        check("t4_no_reissue", int'(ov_a), 0);

        send_a(6'b111111, 6'b000000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(qa.pop_front());
        check("t5_valid", int'(ov_a), 0);
        check("t5_ready", int'(ir_a), 1);
        check("t5_cls", int'(cls_a), 0);
        check("t5_vote", int'(vote_a), 0);
        send_a(6'b001100, 6'b000011);
        wait_out_a(lat);
        check("t5_after_cls", int'(cls_a), 1);
        check("t5_after_vote", int'(vote_a), 2);
        @(posedge clk);
        #1;

        send_b(16'h30F0, 16'h0000);
        cnt = 0;
        while (!ov_b && cnt < 20) begin
            @(posedge clk);
            #1 cnt++;
        end
        check("t6_latency", cnt, 4);
        check("t6_cls", int'(cls_b), 1);
        check("t6_vote", int'(vote_b), 2);
        @(posedge clk);
        #1;

        rnd_or = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send_b(16'($urandom), 16'($urandom));
        end
        rnd_or = 1'b0;
        #1 or_b = 1'b1;

        cnt = 0;
        while ((qa.size() != 0 || qb.size() != 0) && cnt < 200) begin
            @(posedge clk);
            cnt++;
        end
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
